// File: rtl/lbist_pkg.sv
// Shared types and helpers for the logic-BIST pattern/signature engine.
package lbist_pkg;

  // Engine sequencing states; exported as a debug output by the top level.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CMP   = 2'd3
  } lbist_state_e;

  // Default feedback taps, zero-extended so any WIDTH up to 64 can slice them.
  localparam logic [63:0] DEF_LFSR_POLY = 64'h0000_0000_0400_0007;
  localparam logic [63:0] DEF_MISR_POLY = 64'h0000_0000_04C1_1DB7;

  // Rotate the low w bits of v left by n positions (n taken modulo w).
  // Bits at and above w are returned as zero.
  function automatic logic [63:0] rotl(input logic [63:0] v,
                                       input int unsigned w,
                                       input int unsigned n);
    logic [63:0] r;
    r = '0;
    if (w != 0) begin
      for (int unsigned i = 0; i < 64; i++) begin
        if (i < w) r[(i + n) % w] = v[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lbist_shreg.sv
// Generic Galois shift register: parallel load, or a step that shifts left,
// folds the feedback taps in when the MSB falls out, and XORs in xin.
// Used with xin tied to zero as a pattern LFSR, and with data as a MISR.
module lbist_shreg #(
  parameter int             W    = 32,
  parameter logic [W-1:0]   POLY = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic [W-1:0] xin,
  output logic [W-1:0] q
);

  // Load has priority over step; otherwise the register holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (step) begin
      q <= {q[W-2:0], 1'b0} ^ (q[W-1] ? POLY : '0) ^ xin;
    end
  end

endmodule

// File: rtl/lbist_misr_engine.sv
// Logic-BIST engine: drives LFSR patterns into the datapath, compacts the
// response channels into a MISR signature and compares it with a run-time
// golden value. Also flags lockstep divergence between channels 0 and 1.
//
// Handshake: start is a single-cycle request honoured only in IDLE with a
// non-zero pattern count; done is a single-cycle pulse qualifying pass/fail,
// which then hold until the next accepted start. There is no backpressure.
module lbist_misr_engine
  import lbist_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               N_CH      = 2,
  parameter int               CNT_W     = 16,
  parameter int               RESP_LAT  = 1,
  parameter logic [WIDTH-1:0] LFSR_POLY = DEF_LFSR_POLY[WIDTH-1:0],
  parameter logic [WIDTH-1:0] MISR_POLY = DEF_MISR_POLY[WIDTH-1:0]
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_W-1:0]      num_patterns,
  input  logic [WIDTH-1:0]      seed,
  input  logic [WIDTH-1:0]      golden,
  input  logic [N_CH*WIDTH-1:0] resp,
  output logic [WIDTH-1:0]      pattern,
  output logic                  test_en,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  lockstep_err,
  output logic [WIDTH-1:0]      signature,
  output lbist_state_e          state_dbg
);

  lbist_state_e     state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] num_q;
  logic [2:0]       dcnt;
  logic             pass_q;
  logic             fail_q;
  logic             lock_q;

  logic             accept;
  logic             abort_ok;
  logic             tail;
  logic             absorb;
  logic             lock_diff;
  logic             sig_match;
  logic [WIDTH-1:0] seed_eff;
  logic [WIDTH-1:0] fold;
  logic [63:0]      rot_w;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] misr_q;

  assign accept    = (state == ST_IDLE) && start && (num_patterns != '0);
  assign abort_ok  = abort && ((state == ST_RUN) || (state == ST_DRAIN));
  assign seed_eff  = (seed == '0) ? WIDTH'(1) : seed;
  assign absorb    = tail && ((state == ST_RUN) || (state == ST_DRAIN)) && !abort;
  assign sig_match = (misr_q == golden);

  // Channel fold: each channel is rotated by its index so identical
  // channels do not cancel each other in the XOR.
  always_comb begin
    fold  = '0;
    rot_w = '0;
    for (int c = 0; c < N_CH; c++) begin
      rot_w = rotl(64'(resp[c*WIDTH +: WIDTH]), WIDTH, c);
      fold  = fold ^ rot_w[WIDTH-1:0];
    end
  end

  generate
    if (N_CH >= 2) begin : g_lock
      assign lock_diff = (resp[WIDTH +: WIDTH] != resp[0 +: WIDTH]);
    end else begin : g_nolock
      assign lock_diff = 1'b0;
    end

    if (RESP_LAT == 0) begin : g_nolat
      assign tail = (state == ST_RUN);
    end else begin : g_lat
      logic [RESP_LAT-1:0] vpipe;
      // Valid pipe: one bit per presented pattern, cleared when idle or aborted.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vpipe <= '0;
        end else if ((state == ST_IDLE) || abort_ok) begin
          vpipe <= '0;
        end else begin
          vpipe <= (vpipe << 1) | RESP_LAT'(state == ST_RUN);
        end
      end
      assign tail = vpipe[RESP_LAT-1];
    end
  endgenerate

  lbist_shreg #(.W(WIDTH), .POLY(LFSR_POLY)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (seed_eff),
    .step     (state == ST_RUN),
    .xin      ('0),
    .q        (lfsr_q)
  );

  lbist_shreg #(.W(WIDTH), .POLY(MISR_POLY)) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val ('0),
    .step     (absorb),
    .xin      (fold),
    .q        (misr_q)
  );

  // Sequencer: pattern/drain counting, registered status outputs, sticky lockstep flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      num_q   <= '0;
      dcnt    <= '0;
      test_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_RUN;
            num_q   <= num_patterns;
            cnt     <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            lock_q  <= 1'b0;
            busy    <= 1'b1;
            test_en <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            test_en <= 1'b0;
          end else if (cnt == num_q - CNT_W'(1)) begin
            if (RESP_LAT == 0) begin
              state   <= ST_CMP;
              test_en <= 1'b0;
              done    <= 1'b1;
            end else begin
              state <= ST_DRAIN;
              dcnt  <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            test_en <= 1'b0;
          end else if (dcnt == 3'(RESP_LAT - 1)) begin
            state   <= ST_CMP;
            test_en <= 1'b0;
            done    <= 1'b1;
          end else begin
            dcnt <= dcnt + 3'd1;
          end
        end
        ST_CMP: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          pass_q <= sig_match;
          fail_q <= !sig_match;
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          test_en <= 1'b0;
        end
      endcase
      if (absorb && lock_diff) lock_q <= 1'b1;
    end
  end

  // golden is sampled during the compare cycle itself, so pass/fail come
  // straight from the comparator then and from the held copy afterwards.
  assign pass         = (state == ST_CMP) ? sig_match  : pass_q;
  assign fail         = (state == ST_CMP) ? !sig_match : fail_q;
  assign pattern      = lfsr_q;
  assign signature    = misr_q;
  assign lockstep_err = lock_q;
  assign state_dbg    = state;

endmodule
